edge_dff: RTL and testbench

EDGE_DFF -- requirements
Module: edge_dff

---
 rtl/edge_dff_if.sv | 10 +
 rtl/edge_dff.sv | 34 +++
 tb/tb_edge_dff.sv | 103 ++++++++++
 3 files changed

// File: rtl/edge_dff_if.sv
// Data/output bundle of the negative-edge D flip-flop; clk and clear stay plain ports.
`timescale 1ns/1ps
interface edge_dff_if;
   logic d;
   logic q;
   logic qbar;

   modport master (output d, input q, input qbar);
   modport slave  (input d, output q, output qbar);
endinterface

// File: rtl/edge_dff.sv
// Negative-edge-triggered D flip-flop with asynchronous active-high clear,
// built as the classic six-NAND edge network (no behavioural storage).
`timescale 1ns/1ps
module edge_dff (
   input  logic        clk,
   input  logic        clear,
   edge_dff_if.slave   port
);
   logic clk_n;
   logic clear_n;
   logic n1;
   logic n2;
   logic n3;
   logic n4;
   logic q_int;
   logic qbar_int;

   assign clk_n   = ~clk;
   assign clear_n = ~clear;

   // Input latches: with clk high (clk_n=0) n2/n3 sit at 1 and n1 tracks d;
   // when clk falls, the latches freeze d's value into n2 (set) or n3 (reset).
   assign n1 = ~(n4 & n2);
   assign n2 = ~(n1 & clk_n & clear_n);
   assign n3 = ~(n2 & clk_n & n4);
   assign n4 = ~(n3 & port.d & clear_n);

   // Output latch; clear forces qbar high and thereby q low.
   assign q_int    = ~(n2 & qbar_int);
   assign qbar_int = ~(q_int & n3 & clear_n);

   assign port.q    = q_int;
   assign port.qbar = qbar_int;
endmodule

// File: tb/tb_edge_dff.sv
// Directed bench for edge_dff: clear, data transfer, glitch immunity and clear override.
`timescale 1ns/1ps
module tb_edge_dff;
   logic clk   = 1'b0;
   logic clear = 1'b1;
   int unsigned total  = 0;
   int unsigned passed = 0;

   edge_dff_if bus ();

   edge_dff dut (
      .clk   (clk),
      .clear (clear),
      .port  (bus.slave)
   );

   initial bus.d = 1'b0;

   // 100 ns period, low first: rising edges at 50+100k, falling edges at 100k.
   always #50 clk = ~clk;

   task automatic goto(input int unsigned t);
      if (t > $time) #(t - $time);
   endtask

   task automatic check(input string tag, input logic exp_q);
      total++;
      assert (bus.q === exp_q) passed++;
      else $error("FAIL %s: q=%b expected %b", tag, bus.q, exp_q);
      total++;
      assert (bus.qbar === ~exp_q) passed++;
      else $error("FAIL %s_qbar: qbar=%b expected %b", tag, bus.qbar, ~exp_q);
   endtask

   // 20 toggles at 1 ns spacing; d ends at its starting value.
   task automatic burst();
      for (int i = 0; i < 20; i++) begin
         bus.d = ~bus.d;
         #1;
      end
   endtask

   initial begin
      // Clear held across the falling edge at 100 ns
      goto(10);   check("clear_on", 1'b0);
      goto(105);  check("clear_at_fall", 1'b0);
      goto(110);  clear = 1'b0;
      goto(115);  check("clear_release", 1'b0);
      goto(205);  check("hold0_cyc1", 1'b0);
      goto(305);  check("hold0_cyc2", 1'b0);

      // Data transfer
      goto(355);  bus.d = 1'b1;
      goto(395);  check("pre_fall_d1", 1'b0);
      goto(405);  check("load_d1", 1'b1);
      goto(505);  check("keep_d1", 1'b1);
      goto(555);  bus.d = 1'b0;
      goto(605);  check("load_d0", 1'b0);

      // Glitches while clk high, d=0 then d=1
      goto(660);  burst();
      goto(690);  check("gl_hi_d0_mid", 1'b0);
      goto(705);  check("gl_hi_d0_fall", 1'b0);
      goto(755);  bus.d = 1'b1;
      goto(805);  check("load_d1_b", 1'b1);
      goto(860);  burst();
      goto(890);  check("gl_hi_d1_mid", 1'b1);
      goto(905);  check("gl_hi_d1_fall", 1'b1);

      // Glitches while clk low, d=1 then d=0
      goto(910);  burst();
      goto(940);  check("gl_lo_d1_mid", 1'b1);
      goto(1005); check("gl_lo_d1_fall", 1'b1);
      bus.d = 1'b0;
      goto(1010); burst();
      goto(1040); check("gl_lo_d0_held", 1'b1);
      goto(1105); check("gl_lo_d0_fall", 1'b0);

      // Clear override of a stored 1
      goto(1155); bus.d = 1'b1;
      goto(1205); check("load_d1_c", 1'b1);
      goto(1275); clear = 1'b1;
      goto(1276); check("clr_mid_high", 1'b0);
      goto(1305); check("clr_over_fall", 1'b0);
      goto(1320); clear = 1'b0;
      goto(1330); check("clr_rel_hold", 1'b0);
      goto(1405); check("reload_after_clr", 1'b1);

      // Rising edge must not load
      goto(1420); bus.d = 1'b0;
      goto(1455); check("rise_no_load", 1'b1);
      goto(1505); check("load_d0_b", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past 100000 ns, required finish by 1505 ns");
      $fatal(1, "timeout");
   end
endmodule
